// File: rtl/rv32i_types.sv
// Shared types for the rv32i instruction-fetch front end.
// The fetch FSM state encoding and the queue entry layout live here so the
// front end, its FIFO and any bench or checker agree on them.
package rv32i_types;

  // PC width that the queue entry is laid out with.
  localparam int unsigned FETCH_XLEN = 32;

  // IDLE: no request on port A.
  // REQ : request outstanding for the current fetch PC.
  // DROP: request outstanding whose response must be thrown away (a redirect
  //       arrived while it was in flight).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } if_state_t;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with a single-cycle flush.
// Pointers carry one extra wrap bit so full and empty are told apart and the
// occupancy is simply their difference. Storage is not reset; the head is
// only meaningful while valid is high.
module fetch_fifo
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  fetch_entry_t mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // Pointer update: flush empties the queue and overrides push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Entry storage write; a flushed cycle never writes.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign count = wr_ptr - rd_ptr;
  assign valid = (count != '0);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues reads on port A and
// buffers fetched instructions with their PCs for decode.
// Optional build macro IF_PERF_EN adds saturating fetch/drop counters.
//
// Handshakes:
//  - Port A: read_a and address_a are held stable from the cycle read_a rises
//    until the cycle resp_a is seen; at most one request is outstanding and a
//    request is never withdrawn. A redirect during an outstanding request
//    moves the FSM to DROP so the late response is absorbed and discarded.
//  - Decode: an entry is transferred on a cycle where inst_valid && inst_ready
//    and no redirect is present; redirect wins over pop and push.
module if_prefetch_queue
  import rv32i_types::*;
#(
  parameter int unsigned     XLEN     = FETCH_XLEN,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0060
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            read_a,
  output logic [XLEN-1:0] address_a,
  input  logic            resp_a,
  input  logic [31:0]     rdata_a,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output if_state_t       dbg_state
`ifdef IF_PERF_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_drop_cnt
`endif
);

  localparam int unsigned     CW         = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(3);

  if_state_t       state;
  if_state_t       state_n;
  logic [XLEN-1:0] fpc;
  logic [XLEN-1:0] fpc_n;
  logic [XLEN-1:0] hold_addr;
  logic [XLEN-1:0] redirect_target;

  logic            push;
  logic            pop;
  logic            fifo_valid;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_after;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  assign redirect_target = redirect_pc & ~ALIGN_MASK;

  // Redirect suppresses both queue operations for that cycle.
  assign push = (state == REQ) && resp_a && !redirect;
  assign pop  = fifo_valid && inst_ready && !redirect;

  assign count_after = count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

  assign push_entry.pc   = fpc;
  assign push_entry.inst = rdata_a;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .valid     (fifo_valid),
    .count     (count)
  );

  // FSM state, fetch PC and the address held while a dropped request drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fpc       <= RESET_PC;
      hold_addr <= RESET_PC;
    end else begin
      state <= state_n;
      fpc   <= fpc_n;
      if (state == REQ) hold_addr <= fpc;
    end
  end

  // Next state and next fetch PC; redirect has top priority in every state.
  always_comb begin
    state_n = state;
    fpc_n   = fpc;
    unique case (state)
      IDLE: begin
        if (redirect) begin
          fpc_n = redirect_target;
        end else if (count < FULL_COUNT) begin
          state_n = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          fpc_n   = redirect_target;
          state_n = resp_a ? IDLE : DROP;
        end else if (resp_a) begin
          fpc_n   = fpc + PC_STEP;
          state_n = (count_after < FULL_COUNT) ? REQ : IDLE;
        end
      end
      DROP: begin
        if (redirect) begin
          fpc_n   = redirect_target;
          state_n = resp_a ? IDLE : DROP;
        end else if (resp_a) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign read_a     = (state != IDLE);
  assign address_a  = (state == DROP) ? hold_addr : fpc;
  assign inst_valid = fifo_valid;
  assign inst       = fifo_valid ? head.inst : 32'h0;
  assign inst_pc    = fifo_valid ? head.pc   : '0;
  assign dbg_state  = state;

`ifdef IF_PERF_EN
  logic drop_event;

  // A response is discarded when draining in DROP or when a redirect lands on it.
  assign drop_event = resp_a && ((state == DROP) || ((state == REQ) && redirect));

  // Saturating counters of accepted pushes and discarded responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= 32'h0;
      perf_drop_cnt  <= 32'h0;
    end else begin
      if (push && (perf_fetch_cnt != 32'hFFFF_FFFF))
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (drop_event && (perf_drop_cnt != 32'hFFFF_FFFF))
        perf_drop_cnt <= perf_drop_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue (DEPTH=4, RESET_PC=0x60).
// Inputs change 1 ns after the rising edge; all DUT outputs are registered,
// so they are sampled in the same window.
module tb_if_prefetch_queue;
  import rv32i_types::*;

  logic        clk;
  logic        rst_n;
  logic        read_a;
  logic [31:0] address_a;
  logic        resp_a;
  logic [31:0] rdata_a;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  if_state_t   dbg_state;
`ifdef IF_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_drop_cnt;
`endif

  int tests;
  int fails;
  int age;

  if_prefetch_queue #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h0000_0060)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .read_a      (read_a),
    .address_a   (address_a),
    .resp_a      (resp_a),
    .rdata_a     (rdata_a),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .dbg_state   (dbg_state)
`ifdef IF_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_drop_cnt  (perf_drop_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Memory model: answers a request after it has been visible for lat cycles.
  task automatic mem_drive(input int lat);
    if (read_a && age == lat) begin
      resp_a  = 1'b1;
      rdata_a = mem_data(address_a);
      age     = 0;
    end else begin
      resp_a  = 1'b0;
      rdata_a = 32'h0;
      age     = read_a ? age + 1 : 0;
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    resp_a      = 1'b0;
    rdata_a     = 32'h0;
    inst_ready  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    age         = 0;
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; resp_a = 1'b0; rdata_a = 32'h0; inst_ready = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0; age = 0;
    repeat (2) cycle();
    tests++; if (read_a !== 1'b0) begin fails++; $display("FAIL reset_read_a: got %b expected 0", read_a); end
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL reset_inst_valid: got %b expected 0", inst_valid); end
    tests++; if (address_a !== 32'h60) begin fails++; $display("FAIL reset_address_a: got %h expected 00000060", address_a); end
    tests++; if (inst !== 32'h0) begin fails++; $display("FAIL reset_inst: got %h expected 0", inst); end
    tests++; if (inst_pc !== 32'h0) begin fails++; $display("FAIL reset_inst_pc: got %h expected 0", inst_pc); end
    tests++; if (dbg_state !== IDLE) begin fails++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); end
`ifdef IF_PERF_EN
    tests++; if (perf_fetch_cnt !== 32'h0) begin fails++; $display("FAIL reset_perf_fetch: got %0d expected 0", perf_fetch_cnt); end
    tests++; if (perf_drop_cnt !== 32'h0) begin fails++; $display("FAIL reset_perf_drop: got %0d expected 0", perf_drop_cnt); end
`endif
    rst_n = 1'b1;
    #1;
    tests++; if (read_a !== 1'b0) begin fails++; $display("FAIL release_same_cycle_read_a: got %b expected 0", read_a); end
    cycle();
    tests++; if (read_a !== 1'b1) begin fails++; $display("FAIL first_req_read_a: got %b expected 1", read_a); end
    tests++; if (address_a !== 32'h60) begin fails++; $display("FAIL first_req_address: got %h expected 00000060", address_a); end
  endtask

  task automatic test_stream();
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] next_addr;
    int          seen;
    int          resps;
    do_reset();
    inst_ready = 1'b1;
    exp_valid  = 1'b0;
    exp_pc     = 32'h0;
    next_addr  = 32'h60;
    seen       = 0;
    resps      = 0;
    for (int c = 0; c < 8; c++) begin
      tests++; if (inst_valid !== exp_valid) begin fails++; $display("FAIL stream_valid c%0d: got %b expected %b", c, inst_valid, exp_valid); end
      if (exp_valid) begin
        seen++;
        tests++; if (inst_pc !== exp_pc) begin fails++; $display("FAIL stream_pc c%0d: got %h expected %h", c, inst_pc, exp_pc); end
        tests++; if (inst !== mem_data(exp_pc)) begin fails++; $display("FAIL stream_inst c%0d: got %h expected %h", c, inst, mem_data(exp_pc)); end
      end
      if (resps < 3) mem_drive(1);
      else begin resp_a = 1'b0; rdata_a = 32'h0; end
      exp_valid = resp_a;
      exp_pc    = address_a;
      if (resp_a) begin
        tests++; if (address_a !== next_addr) begin fails++; $display("FAIL stream_addr: got %h expected %h", address_a, next_addr); end
        next_addr = next_addr + 32'd4;
        resps++;
      end
      cycle();
    end
    tests++; if (seen !== 3) begin fails++; $display("FAIL stream_count: got %0d expected 3", seen); end
  endtask

  task automatic test_fill();
    int resps;
    do_reset();
    inst_ready = 1'b0;
    resps = 0;
    for (int c = 0; c < 8; c++) begin
      mem_drive(0);
      if (resp_a) resps++;
      cycle();
    end
    resp_a = 1'b0;
    tests++; if (resps !== 4) begin fails++; $display("FAIL fill_requests: got %0d expected 4", resps); end
    tests++; if (read_a !== 1'b0) begin fails++; $display("FAIL fill_read_a: got %b expected 0", read_a); end
    tests++; if (inst_valid !== 1'b1) begin fails++; $display("FAIL fill_valid: got %b expected 1", inst_valid); end
    tests++; if (inst_pc !== 32'h60) begin fails++; $display("FAIL fill_head_pc: got %h expected 00000060", inst_pc); end
    inst_ready = 1'b1;
    cycle();
    inst_ready = 1'b0;
    tests++; if (inst_pc !== 32'h64) begin fails++; $display("FAIL fill_after_pop_pc: got %h expected 00000064", inst_pc); end
    tests++; if (read_a !== 1'b0) begin fails++; $display("FAIL fill_after_pop_read_a: got %b expected 0", read_a); end
    cycle();
    tests++; if (read_a !== 1'b1) begin fails++; $display("FAIL refill_read_a: got %b expected 1", read_a); end
    tests++; if (address_a !== 32'h70) begin fails++; $display("FAIL refill_address: got %h expected 00000070", address_a); end
  endtask

  task automatic test_redirect_pending();
    logic found;
    do_reset();
    inst_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (read_a && address_a == 32'h68) begin
        found = 1'b1;
        break;
      end
      mem_drive(2);
      cycle();
    end
    tests++; if (found !== 1'b1) begin fails++; $display("FAIL redir_reach_0x68: got %b expected 1", found); end
    resp_a = 1'b0; rdata_a = 32'h0;
    redirect = 1'b1; redirect_pc = 32'h203;
    cycle();
    redirect = 1'b0; redirect_pc = 32'h0;
    tests++; if (dbg_state !== DROP) begin fails++; $display("FAIL redir_state_drop: got %0d expected %0d", dbg_state, DROP); end
    tests++; if (address_a !== 32'h68) begin fails++; $display("FAIL redir_hold_addr_a: got %h expected 00000068", address_a); end
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL redir_flush_valid: got %b expected 0", inst_valid); end
    cycle();
    tests++; if (read_a !== 1'b1) begin fails++; $display("FAIL redir_hold_read_a: got %b expected 1", read_a); end
    tests++; if (address_a !== 32'h68) begin fails++; $display("FAIL redir_hold_addr_b: got %h expected 00000068", address_a); end
    resp_a = 1'b1; rdata_a = 32'hBAD0_BAD0;
    cycle();
    resp_a = 1'b0; rdata_a = 32'h0;
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL redir_drop_valid: got %b expected 0", inst_valid); end
    tests++; if (read_a !== 1'b0) begin fails++; $display("FAIL redir_idle_read_a: got %b expected 0", read_a); end
    cycle();
    tests++; if (read_a !== 1'b1) begin fails++; $display("FAIL redir_new_read_a: got %b expected 1", read_a); end
    tests++; if (address_a !== 32'h200) begin fails++; $display("FAIL redir_new_addr: got %h expected 00000200", address_a); end
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL redir_wait_valid: got %b expected 0", inst_valid); end
    resp_a = 1'b1; rdata_a = mem_data(32'h200); inst_ready = 1'b0;
    cycle();
    resp_a = 1'b0; rdata_a = 32'h0;
    tests++; if (inst_valid !== 1'b1) begin fails++; $display("FAIL redir_data_valid: got %b expected 1", inst_valid); end
    tests++; if (inst_pc !== 32'h200) begin fails++; $display("FAIL redir_data_pc: got %h expected 00000200", inst_pc); end
    tests++; if (inst !== mem_data(32'h200)) begin fails++; $display("FAIL redir_data_inst: got %h expected %h", inst, mem_data(32'h200)); end
  endtask

  task automatic test_redirect_resp_pop();
    do_reset();
    inst_ready = 1'b0;
    mem_drive(0);
    cycle();
    mem_drive(0);
    cycle();
    tests++; if (inst_pc !== 32'h60) begin fails++; $display("FAIL rrp_pre_head: got %h expected 00000060", inst_pc); end
    tests++; if (address_a !== 32'h68) begin fails++; $display("FAIL rrp_pre_addr: got %h expected 00000068", address_a); end
    resp_a = 1'b1; rdata_a = mem_data(32'h68);
    inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
    cycle();
    resp_a = 1'b0; rdata_a = 32'h0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL rrp_flush_valid: got %b expected 0", inst_valid); end
    tests++; if (read_a !== 1'b0) begin fails++; $display("FAIL rrp_idle_read_a: got %b expected 0", read_a); end
    tests++; if (dbg_state !== IDLE) begin fails++; $display("FAIL rrp_state: got %0d expected %0d", dbg_state, IDLE); end
    cycle();
    tests++; if (read_a !== 1'b1) begin fails++; $display("FAIL rrp_new_read_a: got %b expected 1", read_a); end
    tests++; if (address_a !== 32'h300) begin fails++; $display("FAIL rrp_new_addr: got %h expected 00000300", address_a); end
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL rrp_no_push: got %b expected 0", inst_valid); end
  endtask

  task automatic test_reset_in_drop();
    do_reset();
    inst_ready = 1'b0;
    mem_drive(0);
    cycle();
    resp_a = 1'b0; rdata_a = 32'h0;
    redirect = 1'b1; redirect_pc = 32'h400;
    cycle();
    redirect = 1'b0; redirect_pc = 32'h0;
    tests++; if (dbg_state !== DROP) begin fails++; $display("FAIL rdrop_pre_state: got %0d expected %0d", dbg_state, DROP); end
`ifdef IF_PERF_EN
    tests++; if (perf_fetch_cnt !== 32'd1) begin fails++; $display("FAIL rdrop_pre_perf_fetch: got %0d expected 1", perf_fetch_cnt); end
`endif
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (read_a !== 1'b0) begin fails++; $display("FAIL rdrop_read_a: got %b expected 0", read_a); end
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL rdrop_valid: got %b expected 0", inst_valid); end
    tests++; if (address_a !== 32'h60) begin fails++; $display("FAIL rdrop_address: got %h expected 00000060", address_a); end
    tests++; if (dbg_state !== IDLE) begin fails++; $display("FAIL rdrop_state: got %0d expected %0d", dbg_state, IDLE); end
`ifdef IF_PERF_EN
    tests++; if (perf_fetch_cnt !== 32'h0) begin fails++; $display("FAIL rdrop_perf_fetch: got %0d expected 0", perf_fetch_cnt); end
    tests++; if (perf_drop_cnt !== 32'h0) begin fails++; $display("FAIL rdrop_perf_drop: got %0d expected 0", perf_drop_cnt); end
`endif
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    tests = 0;
    fails = 0;
    age   = 0;
    test_reset();
    test_stream();
    test_fill();
    test_redirect_pending();
    test_redirect_resp_pop();
    test_reset_in_drop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
